// File: rtl/parity_uart_rx.sv
// parity_uart_rx: serial frame receiver (start, DATA_W bits LSB first, parity, stop) with
// parity and framing error detection; samples at mid-bit from a 2-flop synchronized line.
module parity_uart_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic ODD = PARITY_ODD[0];

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    state_t            state;
    logic [1:0]        sync;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              perr;
    logic              rx_s;
    logic              half;
    logic              full;

    assign rx_s = sync[1];
    assign half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign full = cnt == CW'(CLKS_PER_BIT - 1);
    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync       <= 2'b11;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], rx_in};
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            cnt        <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: if (half) begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= rx_s ? IDLE : DATA;
                end
                DATA: if (full) begin
                    cnt     <= '0;
                    shreg   <= {rx_s, shreg[DATA_W-1:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == BW'(DATA_W - 1)) state <= PARITY;
                end
                PARITY: if (full) begin
                    cnt   <= '0;
                    perr  <= rx_s != (^shreg ^ ODD);
                    state <= STOP;
                end
                // Leaving STOP at mid-bit lets IDLE catch a start edge right after a 1-bit stop.
                STOP: if (full) begin
                    cnt <= '0;
                    if (rx_s) begin
                        data_out   <= shreg;
                        data_valid <= 1'b1;
                        parity_err <= perr;
                        state      <= IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK_WAIT;
                    end
                end
                BREAK_WAIT: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/parity_uart_rx.md
Name: parity_uart_rx

Overview:
- Serial frame receiver that checks parity. It is the receiving end of the team's XOR-based parity-generating serial link.
- Frame format: 1 start bit (0), DATA_W data bits sent LSB first, 1 parity bit, 1 stop bit (1). The line idles high.
- Recovers each data word, recomputes parity as the XOR-reduction of the data, and flags parity and framing errors.
- Sits between the board-level serial pin and the byte-wide consumer logic.

Parameters:
- DATA_W, 8, number of data bits per frame; legal range 5 to 9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and at least 4.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_in  in  1  asynchronous serial line; idles high.
- data_out  out  DATA_W  last received word; holds its value between frames.
- data_valid  out  1  one-cycle pulse; data_out and parity_err are valid in this cycle.
- parity_err  out  1  one-cycle pulse coincident with data_valid when the parity check fails.
- frame_err  out  1  one-cycle pulse when the stop bit samples as 0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; bit counter and sample counter clear.
  - data_out = 0; data_valid, parity_err, frame_err, busy = 0.
  - Both synchronizer flops reset to 1, so reset release does not register as a false start.
- Input sync: rx_in passes through a 2-flop synchronizer giving rx_s. All sampling uses rx_s.
- Sample counter: counts 0 to CLKS_PER_BIT-1 and clears at each sample point.
- IDLE:
  - Stays in IDLE while rx_s = 1.
  - When rx_s = 0, go to START with the counter cleared.
- START:
  - After CLKS_PER_BIT/2 cycles (mid-bit), sample rx_s.
  - If 0: go to DATA, clear the counter and the bit index.
  - If 1: treat as a glitch, return to IDLE and raise no flags.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first, so the first data bit ends up in bit 0.
  - After DATA_W samples, go to PARITY.
- PARITY:
  - After CLKS_PER_BIT cycles, sample p_rx.
  - Compute calc = XOR-reduce(shift register) XOR PARITY_ODD.
  - Latch perr = (p_rx != calc). Go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - If 1: in the next cycle, load data_out from the shift register, pulse data_valid = 1, drive parity_err = perr for that cycle, then go to IDLE.
  - If 0: in the next cycle pulse frame_err = 1, leave data_out unchanged, assert no data_valid, then go to BREAK_WAIT.
- BREAK_WAIT: stay until rx_s = 1, then go to IDLE. This prevents a held-low line (break) from being decoded as repeated frames.
- Latency: data_valid rises 1 clk after the mid-stop-bit sample point.
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends, so a start edge immediately after a 1-bit stop is caught.
- Flag exclusivity: data_valid and frame_err are never high in the same cycle. parity_err is never high without data_valid.
- busy: 1 in START, DATA, PARITY, STOP and BREAK_WAIT; 0 only in IDLE.
- Reset mid-frame: abort immediately to the reset values. Do not emit a partial word.

Test Plan (CLKS_PER_BIT=16, DATA_W=8, PARITY_ODD=0 unless noted):
- Reset, then send 0xA5 with parity bit 0 and stop bit 1 -> exactly one data_valid pulse; data_out = 0xA5; parity_err = 0; frame_err stays 0.
- Send 0x01 with parity bit 0 -> data_valid pulse; data_out = 0x01; parity_err = 1 in the same cycle.
- Send 0x3C with parity bit 0 and stop bit 0, then hold the line low for 40 clks -> one frame_err pulse; no data_valid; data_out keeps its previous value; busy stays 1 until the line returns high, then drops.
- Drive rx_in low for 4 clks only -> FSM returns to IDLE; no data_valid or error pulses; busy high for about 10 clks, then 0.
- Pull rst_n low in the middle of the DATA state of frame 0x55, release it, then send 0xC3 -> all outputs are 0 during reset, no output for 0x55, one clean data_valid with data_out = 0xC3.
- With PARITY_ODD=1, send 0x00 with parity 1 followed immediately by 0xFF with parity 1 (1-bit stops) -> two data_valid pulses, 0x00 then 0xFF, both with parity_err = 0.
